// File: rtl/nios2_oci_dct_capture_ctrl.sv
// nios2_oci_dct_capture_ctrl: packs trace atoms into frames, hands them to the sink, runs the end-of-test flush.
// Optional drop counter is built only when NIOS2_OCI_DCT_DROP_COUNT_EN is defined.
module nios2_oci_dct_capture_ctrl #(
  parameter int ATOM_W    = 2,
  parameter int MAX_ATOMS = 15,
  parameter int DROP_W    = 8,
  localparam int FW = ATOM_W * MAX_ATOMS,
  localparam int CW = $clog2(MAX_ATOMS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  input  logic              test_ending,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [FW-1:0]     dct_buffer,
  output logic [CW-1:0]     dct_count,
  output logic              test_has_ended,
  output logic [DROP_W-1:0] drop_count
);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [FW-1:0] cbuf_q, cbuf_d, buf_q, buf_d;
  logic [CW-1:0] ccnt_q, ccnt_d, cnt_q, cnt_d;
  logic fv_q, fv_d, ted_q, ted_d;
  logic slot_free, full, run, flush, xfer, accept, fin;
  always_comb begin
    slot_free = !fv_q || frame_ready;
    full      = ccnt_q == CW'(MAX_ATOMS);
    run       = state_q == RUN;
    flush     = state_q == FLUSH;
    xfer      = slot_free && (run ? full : flush && ccnt_q != '0);
    accept    = run && atom_valid && (!full || slot_free);
    fin       = flush && ccnt_q == '0 && slot_free;
    // An atom arriving on a transfer edge starts the next frame
    cbuf_d    = xfer ? (accept ? {{(FW-ATOM_W){1'b0}}, atom} : '0)
                     : (accept ? {cbuf_q[FW-ATOM_W-1:0], atom} : cbuf_q);
    ccnt_d    = xfer ? (accept ? CW'(1) : '0) : (accept ? ccnt_q + CW'(1) : ccnt_q);
    buf_d     = xfer ? cbuf_q : buf_q;
    cnt_d     = xfer ? ccnt_q : cnt_q;
    fv_d      = xfer || (fv_q && !frame_ready);
    state_d   = run ? (test_ending ? FLUSH : RUN) : fin ? DONE : state_q;
    ted_d     = ted_q || fin;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cbuf_q  <= '0;
      ccnt_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      ted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cbuf_q  <= cbuf_d;
      ccnt_q  <= ccnt_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      ted_q   <= ted_d;
    end
  end
  assign frame_valid    = fv_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = ted_q;
`ifdef NIOS2_OCI_DCT_DROP_COUNT_EN
  logic drop;
  logic [DROP_W-1:0] drop_q;
  assign drop = atom_valid && !accept;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else if (drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
  end
  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif
endmodule

// File: doc/nios2_oci_dct_capture_ctrl.md
Name: nios2_oci_dct_capture_ctrl

Overview:
Sequencer for the OCI data-capture-trace (DCT) path.
- Packs 2-bit trace atoms from the CPU trace port into 30-bit frames of up to 15 atoms.
- Hands each frame, with its atom count, to the downstream trace sink using a valid/ready handshake.
- Runs the end-of-test flush and raises test_has_ended once the last partial frame has been consumed.

Parameters:
ATOM_W, 2, width of one trace atom
MAX_ATOMS, 15, atoms per full frame; frame width = ATOM_W*MAX_ATOMS = 30
DROP_W, 8, width of the optional drop counter

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
atom_valid  input  1  atom present this cycle; no backpressure to source
atom  input  2  trace atom
test_ending  input  1  level; first high sample starts end-of-test flush
frame_ready  input  1  sink accepts frame when high with frame_valid
frame_valid  output  1  dct_buffer/dct_count hold a frame
dct_buffer  output  30  frame data, newest atom in bits [1:0]
dct_count  output  4  number of valid atoms in dct_buffer (1..15)
test_has_ended  output  1  sticky; flush complete
drop_count  output  8  atoms discarded (only with feature enabled)

Behaviour:
- Reset (async assert, sync release): frame_valid=0, dct_buffer=0, dct_count=0, test_has_ended=0, drop_count=0; collect buffer cbuf=0, ccnt=0; state RUN.
- Storage is two-stage: collect register (cbuf, ccnt) plus output slot (dct_buffer, dct_count, frame_valid).
- slot_free = !frame_valid || frame_ready. Handshake completes on any edge with frame_valid && frame_ready.
- Output slot content holds stable while frame_valid=1 and frame_ready=0.
- Atom accept, state RUN: atom_valid && (ccnt<15 || slot_free). Accept does cbuf <= {cbuf[27:0], atom} and ccnt+1.
- Transfer, state RUN: when ccnt==15 and slot_free, at that edge:
  - dct_buffer <= cbuf, dct_count <= 15, frame_valid <= 1.
  - A simultaneous incoming atom restarts collection: cbuf <= {28'b0, atom}, ccnt <= 1.
- Latency: the 15th atom accepted at edge N gives frame_valid=1 after edge N+1 if the slot is free.
- Drop: atom_valid while ccnt==15 and !slot_free. The atom is discarded and cbuf/ccnt are unchanged.
- A completed handshake with no transfer on the same edge clears frame_valid. dct_buffer/dct_count retain their last value.
- FSM:
  - RUN -> FLUSH on first test_ending=1 sample.
  - FLUSH -> DONE when ccnt==0 and frame_valid==0 (or a handshake completes this edge with nothing pending).
  - DONE is terminal until reset.
- test_ending edge: an atom on the same edge as test_ending is still accepted per RUN rules. test_ending is ignored after the first sample.
- FLUSH:
  - All atom_valid are discarded as drops.
  - If ccnt>0 and slot_free: transfer partial frame at that edge. dct_buffer <= cbuf (right-aligned, upper bits zero), dct_count <= ccnt, ccnt <= 0, cbuf <= 0.
  - A 15-atom frame is flushed identically.
  - If ccnt==0 on entry, no extra frame is produced.
- DONE: test_has_ended=1 registered from the transition edge. frame_valid=0; atoms are dropped.
- Reset mid-frame or mid-flush: all pending data is lost and the block returns to RUN with test_has_ended=0.
- dct_count is never 0 while frame_valid=1.

Optional Feature:
- Macro: NIOS2_OCI_DCT_DROP_COUNT_EN.
- Defined: drop_count increments by 1 per dropped atom in any state, saturating at 2^DROP_W-1, and clears only on reset.
- Undefined: drop_count is tied to 0 and no counter logic is built.

Test Plan:
- Single frame: frame_ready=1, atoms 0,1,2,3,0,1,... x15, one per cycle -> frame_valid one cycle after the 15th atom, dct_count=15, dct_buffer=30'h06C6C6C6 pattern (atom sequence packed oldest at MSBs), no drops.
- Back-to-back: 30 consecutive atoms, frame_ready=1 -> two frames, the second's first atom captured on the transfer edge, no gap, no drops.
- Backpressure: frame_ready=0, 35 atoms -> frame 1 held stable, collect full at 30 atoms, 5 drops (drop_count=5 with macro).
  - Then frame_ready=1 for 1 cycle -> frame 2 moves to slot next edge.
- Partial flush: 7 atoms, then test_ending=1 -> one frame with dct_count=7 and upper 16 bits zero.
  - After handshake, test_has_ended=1 on the following edge, staying high; later atoms are dropped.
- Empty flush: test_ending=1 with ccnt=0, frame_valid=0 -> test_has_ended=1 two edges later, no frame.
- Reset mid-operation: assert reset asynchronously with 9 atoms collected and frame_valid=1 -> all outputs 0 immediately; after release, a fresh 15-atom frame is produced normally.
